alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Request buffer and two-stage pipeline controller that sits directly upstream of the combinational `alu`. It accepts tagged operation requests over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It issues one request per cycle into a registered ALU input stage, then captures the ALU result into a registered response port that also uses valid/ready. Order is strictly preserved, and each tag is returned unchanged with its result.

## Interface
- `WIDTH`, 32: operand and result width; must match the downstream `alu`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TAG_W`, 4: request tag width.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; **synchronous, active-high**.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; equals `count_o != DEPTH`.
- `req_op_i`  in  3  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 XOR, 6 OR, 7 AND.
- `req_a_i`, `req_b_i`  in  WIDTH  operands.
- `req_tag_i`  in  TAG_W  request tag.
- `alu_valid_o`  out  1  issue register holds a live request.
- `alu_op_o`  out  3  registered opcode to the ALU.
- `alu_a_o`, `alu_b_o`  out  WIDTH  registered operands to the ALU.
- `alu_result_i`  in  WIDTH  combinational result from the ALU.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `rsp_result_o`  out  WIDTH  registered result.
- `rsp_tag_o`  out  TAG_W  tag of the response.
- `count_o`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH; excludes the issue and response stages.

## Operation
- **Push:** the FIFO pushes when `req_valid_i && req_ready_o`. The pushed entry is {op, a, b, tag}. There is no bypass, so every request passes through the FIFO.
- **Pipeline stages:** the FIFO feeds stage S1 (issue register), which feeds stage S2 (response register). `alu_*_o` are driven directly from S1.
- **S2 free:** `s2_free = !rsp_valid_o || rsp_ready_i`.
- **S1 advance:** `s1_adv = alu_valid_o && s2_free`.
  - S2 loads `alu_result_i` and the S1 tag.
  - `rsp_valid_o` is set to 1.
- **S2 drain:** if `s2_free` and S1 is not advancing, `rsp_valid_o` clears.
- **S1 load:** S1 loads the FIFO head (pop) when `count_o != 0 && (!alu_valid_o || s1_adv)`. Otherwise, if `s1_adv`, `alu_valid_o` clears.
- **Idle S1:** when `alu_valid_o` is 0, `alu_op_o`/`alu_a_o`/`alu_b_o` hold their last values. This avoids ALU input toggling.
- **Stall:** when `rsp_valid_o && !rsp_ready_i`, S2, S1 and the FIFO head are all frozen. Pushes continue until the FIFO is full.
- **Simultaneous push and pop:** `count_o` is unchanged. At `count_o == DEPTH`, `req_ready_o` is 0, so there is no push even if a pop occurs that cycle.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- **Response stability:** `rsp_result_o` and `rsp_tag_o` are stable while `rsp_valid_o && !rsp_ready_i`.
- **Arithmetic:** none in this block. The result is captured at full WIDTH exactly as the ALU produces it, with no truncation or extension.

## Timing
- **Reset values** (`rst_i` high at a rising edge):
  - `count_o` = 0 and both pointers = 0.
  - `alu_valid_o` = 0, `rsp_valid_o` = 0.
  - `alu_op_o` = 0 (ADD); `alu_a_o`, `alu_b_o`, `rsp_result_o`, `rsp_tag_o` = 0.
  - `req_ready_o` = 1 from the first cycle after reset.
- **Reset mid-operation:** all queued, issued and pending responses are discarded, with no partial response. Requests presented during reset are not accepted.
- **Latency into an empty pipe:**
  - Request accepted at edge E.
  - S1 loaded at edge E+1, so `alu_valid_o` = 1 in cycle E+1.
  - Response registered at edge E+2, so `rsp_valid_o` = 1 in cycle E+2.
- **Throughput:** 1 request per cycle sustained while `rsp_ready_i` = 1.
- **Capacity:** with the response stalled, at most DEPTH+2 requests are in flight.
- **`req_ready_o` timing:** derived from registered count only; there is no combinational path from `rsp_ready_i`.

## Test plan
- **Single ADD:** reset, then push ADD a=5, b=7, tag=3 at edge 0 with `rsp_ready_i` = 1. Required: `alu_valid_o` = 1 in cycle 1; `rsp_valid_o` = 1 in cycle 2 only, with `rsp_result_o` = 0x0000000C and `rsp_tag_o` = 3.
- **Back-to-back stream:** push 4 ops on consecutive cycles: SUB 3−5, SLL 1 by b=33, SRA 0x80000000 by 4, AND 0xF0F0F0F0 & 0x0FF00FF0. Required: responses 0xFFFFFFFE, 0x00000002, 0xF8000000, 0x00F000F0 on 4 consecutive cycles, tags in push order.
- **Backpressure fill:** hold `rsp_ready_i` = 0 and push 8 requests continuously. Required:
  - Exactly 6 accepted; `req_ready_o` = 0 afterward with `count_o` = 4.
  - `rsp_result_o` stays frozen.
  - After releasing `rsp_ready_i`, all 6 responses drain in order, one per cycle.
- **Simultaneous push/pop at count 2:** push while popping in the same cycle. Required: `count_o` stays 2 and data order is preserved across pointer wrap. Repeat for 3×DEPTH pushes.
- **Reset mid-operation:** with 3 queued, S1 and S2 valid, assert `rst_i` for one cycle. Required: all outputs at reset values the next cycle, and no stale response is ever produced afterward.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: tagged request FIFO feeding a registered ALU issue stage (S1)
// and a registered valid/ready response stage (S2). Order and tags are preserved.
module alu_issue_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_op_i,
  input  logic [WIDTH-1:0]         req_a_i,
  input  logic [WIDTH-1:0]         req_b_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  output logic                     alu_valid_o,
  output logic [2:0]               alu_op_o,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  input  logic [WIDTH-1:0]         alu_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;
  logic             s2_free;
  logic             s1_adv;

  // Handshake and pipeline-advance decisions; ready depends on registered count only
  always_comb begin
    req_ready_o = (count_o != CW'(DEPTH));
    push        = req_valid_i && req_ready_o;
    s2_free     = !rsp_valid_o || rsp_ready_i;
    s1_adv      = alu_valid_o && s2_free;
    pop         = (count_o != CW'(0)) && (!alu_valid_o || s1_adv);
    head        = mem[rd_ptr];
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt = count_o;
    if (push && !pop) begin
      count_nxt = count_o + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count_o - CW'(1);
    end
  end

  // FIFO storage; data only, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};
    end
  end

  // Pointers, count, issue stage and response stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_o      <= '0;
      alu_valid_o  <= 1'b0;
      alu_op_o     <= '0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      s1_tag       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_tag_o    <= '0;
    end else begin
      count_o <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      // S1: load the FIFO head, otherwise retire on advance; operands hold when idle
      if (pop) begin
        alu_valid_o <= 1'b1;
        alu_op_o    <= head.op;
        alu_a_o     <= head.a;
        alu_b_o     <= head.b;
        s1_tag      <= head.tag;
      end else if (s1_adv) begin
        alu_valid_o <= 1'b0;
      end

      // S2: capture the ALU result with its tag, or drain when consumed
      if (s1_adv) begin
        rsp_valid_o  <= 1'b1;
        rsp_result_o <= alu_result_i;
        rsp_tag_o    <= s1_tag;
      end else if (s2_free) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU in the loop.
module tb_alu_issue_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_op_i;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             alu_valid_o;
  logic [2:0]       alu_op_o;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [$clog2(DEPTH):0] count_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .alu_valid_o(alu_valid_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Downstream combinational ALU
  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b[4:0];
      3'd3: return a >> b[4:0];
      3'd4: return WIDTH'($signed(a) >>> b[4:0]);
      3'd5: return a ^ b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_result_i = alu_f(alu_op_o, alu_a_o, alu_b_o);

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
  endtask

  // Compare a response about to be consumed at the next edge against the scoreboard
  task automatic sb_step;
    exp_t e;
    if (rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra: observed unexpected response tag=%h", rsp_tag_o);
      end else begin
        e = sb.pop_front();
        chk("sb_result", rsp_result_o, e.res);
        chk("sb_tag", 32'(rsp_tag_o), 32'(e.tag));
      end
    end
  endtask

  initial begin
    int k;
    logic rdy;
    logic [2:0] op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_tag_i   = '0;
    rsp_ready_i = 1'b1;
    tick;
    tick;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_alu_valid", 32'(alu_valid_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_alu_op", 32'(alu_op_o), 32'd0);
    chk("rst_rsp_result", rsp_result_o, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;

    // Single ADD: 5 + 7, tag 3
    set_req(3'd0, 32'd5, 32'd7, 4'd3);
    tick;
    req_valid_i = 1'b0;
    chk("add_count_e0", 32'(count_o), 32'd1);
    chk("add_alu_valid_e0", 32'(alu_valid_o), 32'd0);
    tick;
    chk("add_alu_valid_e1", 32'(alu_valid_o), 32'd1);
    chk("add_alu_a", alu_a_o, 32'd5);
    chk("add_alu_b", alu_b_o, 32'd7);
    chk("add_rsp_valid_e1", 32'(rsp_valid_o), 32'd0);
    tick;
    chk("add_rsp_valid_e2", 32'(rsp_valid_o), 32'd1);
    chk("add_rsp_result", rsp_result_o, 32'h0000000C);
    chk("add_rsp_tag", 32'(rsp_tag_o), 32'd3);
    chk("add_alu_valid_e2", 32'(alu_valid_o), 32'd0);
    tick;
    chk("add_rsp_valid_e3", 32'(rsp_valid_o), 32'd0);

    // Back-to-back stream of four ops
    set_req(3'd1, 32'd3, 32'd5, 4'd1);
    tick;
    set_req(3'd2, 32'd1, 32'd33, 4'd2);
    tick;
    set_req(3'd4, 32'h80000000, 32'd4, 4'd3);
    tick;
    chk("str0_valid", 32'(rsp_valid_o), 32'd1);
    chk("str0_result", rsp_result_o, 32'hFFFFFFFE);
    chk("str0_tag", 32'(rsp_tag_o), 32'd1);
    set_req(3'd7, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd4);
    tick;
    req_valid_i = 1'b0;
    chk("str1_valid", 32'(rsp_valid_o), 32'd1);
    chk("str1_result", rsp_result_o, 32'h00000002);
    chk("str1_tag", 32'(rsp_tag_o), 32'd2);
    tick;
    chk("str2_valid", 32'(rsp_valid_o), 32'd1);
    chk("str2_result", rsp_result_o, 32'hF8000000);
    chk("str2_tag", 32'(rsp_tag_o), 32'd3);
    tick;
    chk("str3_valid", 32'(rsp_valid_o), 32'd1);
    chk("str3_result", rsp_result_o, 32'h00F000F0);
    chk("str3_tag", 32'(rsp_tag_o), 32'd4);
    tick;
    chk("str_idle", 32'(rsp_valid_o), 32'd0);

    // Backpressure fill: 8 offered cycles with the response stalled
    rsp_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(3'd0, 32'(32'h100 + k), 32'(k), 4'(k));
      rdy = req_ready_o;
      tick;
      if (rdy) k++;
    end
    req_valid_i = 1'b0;
    chk("bp_accepted", 32'(k), 32'd6);
    chk("bp_count", 32'(count_o), 32'd4);
    chk("bp_req_ready", 32'(req_ready_o), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("bp_result", rsp_result_o, 32'h100);
    chk("bp_tag", 32'(rsp_tag_o), 32'd0);
    chk("bp_alu_valid", 32'(alu_valid_o), 32'd1);
    chk("bp_alu_a", alu_a_o, 32'h101);
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("bp_frozen_result", rsp_result_o, 32'h100);
      chk("bp_frozen_tag", 32'(rsp_tag_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("bp_drain_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_drain_result", rsp_result_o, 32'(32'h100 + 2 * j));
      chk("bp_drain_tag", 32'(rsp_tag_o), 32'(j));
      tick;
    end
    chk("bp_drain_done", 32'(rsp_valid_o), 32'd0);
    chk("bp_drain_count", 32'(count_o), 32'd0);

    // Steady push/pop at count 2 across pointer wrap, 3*DEPTH pushes
    rsp_ready_i = 1'b0;
    for (int n = 0; n < 3 * DEPTH; n++) begin
      if (n == 4) begin
        chk("pp_count_built", 32'(count_o), 32'd2);
        rsp_ready_i = 1'b1;
      end
      op = 3'(n);
      a  = 32'h12345670 ^ 32'(n * 32'h01010101);
      b  = 32'(n + 1);
      set_req(op, a, b, 4'(n));
      sb_step;
      chk("pp_req_ready", 32'(req_ready_o), 32'd1);
      sb.push_back('{res: alu_f(op, a, b), tag: 4'(n)});
      tick;
      if (n >= 4) chk("pp_count_steady", 32'(count_o), 32'd2);
    end
    req_valid_i = 1'b0;
    for (int w = 0; w < 20 && sb.size() != 0; w++) begin
      sb_step;
      tick;
    end
    chk("pp_drain", 32'(sb.size()), 32'd0);

    // Reset mid-operation: 3 queued, S1 and S2 live
    rsp_ready_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      set_req(3'd0, 32'(n), 32'd1, 4'(n + 8));
      tick;
    end
    chk("mr_count", 32'(count_o), 32'd3);
    chk("mr_alu_valid", 32'(alu_valid_o), 32'd1);
    chk("mr_rsp_valid", 32'(rsp_valid_o), 32'd1);
    rst_i = 1'b1;
    set_req(3'd5, 32'hDEADBEEF, 32'h1, 4'd9);
    tick;
    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    chk("mr_rst_count", 32'(count_o), 32'd0);
    chk("mr_rst_alu_valid", 32'(alu_valid_o), 32'd0);
    chk("mr_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mr_rst_alu_op", 32'(alu_op_o), 32'd0);
    chk("mr_rst_alu_a", alu_a_o, 32'd0);
    chk("mr_rst_alu_b", alu_b_o, 32'd0);
    chk("mr_rst_result", rsp_result_o, 32'd0);
    chk("mr_rst_tag", 32'(rsp_tag_o), 32'd0);
    chk("mr_rst_req_ready", 32'(req_ready_o), 32'd1);
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk("mr_no_stale_rsp", 32'(rsp_valid_o), 32'd0);
      chk("mr_no_stale_alu", 32'(alu_valid_o), 32'd0);
      chk("mr_no_stale_count", 32'(count_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
